// File: rtl/wb_pkg.sv
// Shared widths and the buffered-instruction entry layout for the writeback/commit stage.
package wb_pkg;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_RF_AW  = 5;
  localparam int unsigned WB_CSR_AW = 14;
  localparam int unsigned WB_EXC_W  = 6;

  typedef struct packed {
    logic [WB_DATA_W-1:0] pc;
    logic                 rf_we;
    logic [WB_RF_AW-1:0]  rf_waddr;
    logic [WB_DATA_W-1:0] rf_wdata;
    logic                 csr_we;
    logic [WB_CSR_AW-1:0] csr_num;
    logic [WB_DATA_W-1:0] csr_mask;
    logic [WB_DATA_W-1:0] csr_wdata;
    logic [WB_EXC_W-1:0]  exc;
    logic                 ertn;
    logic [WB_DATA_W-1:0] fault_vaddr;
  } wb_entry_t;

  // Flat width of an entry with the field order of wb_entry_t, for any parameterisation.
  function automatic int unsigned entry_w(input int unsigned dw, input int unsigned aw,
                                          input int unsigned cw, input int unsigned ew);
    return 5 * dw + aw + cw + ew + 3;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order circular buffer with push/pop/flush, occupancy count and per-slot valid/tag views.
module wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 8,
  parameter int unsigned TAG_W = 6
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            push,
  input  logic                            pop,
  input  logic                            flush,
  input  logic [W-1:0]                    wdata,
  input  logic [TAG_W-1:0]                wtag,
  output logic [W-1:0]                    head,
  output logic                            head_valid,
  output logic [$clog2(DEPTH+1)-1:0]      count,
  output logic [DEPTH-1:0]                vld,
  output logic [DEPTH-1:0][TAG_W-1:0]     tags
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][W-1:0]     mem_q;
  logic [DEPTH-1:0][TAG_W-1:0] tag_q;
  logic [DEPTH-1:0]            vld_q;
  logic [PW-1:0]               head_q, tail_q;
  logic [CW-1:0]               cnt_q;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
    end else begin
      // Pop before push so a same-slot push on a full buffer leaves the slot valid.
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= nxt(head_q);
      end
      if (push) begin
        vld_q[tail_q] <= 1'b1;
        tail_q        <= nxt(tail_q);
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (pop && !push) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && !flush && push) begin
      mem_q[tail_q] <= wdata;
      tag_q[tail_q] <= wtag;
    end
  end

  assign head       = mem_q[head_q];
  assign head_valid = (cnt_q != '0);
  assign count      = cnt_q;
  assign vld        = vld_q;
  assign tags       = tag_q;

endmodule

// File: rtl/wb_commit_buf.sv
// Writeback/commit stage: buffers completed instructions, retires one per cycle in order,
// and flushes on exception/ertn at the head or on external cancel.
module wb_commit_buf
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W = WB_DATA_W,
  parameter int unsigned RF_AW  = WB_RF_AW,
  parameter int unsigned CSR_AW = WB_CSR_AW,
  parameter int unsigned EXC_W  = WB_EXC_W,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_allowin,
  input  logic [DATA_W-1:0]     in_pc,
  input  logic                  in_rf_we,
  input  logic [RF_AW-1:0]      in_rf_waddr,
  input  logic [DATA_W-1:0]     in_rf_wdata,
  input  logic                  in_csr_we,
  input  logic [CSR_AW-1:0]     in_csr_num,
  input  logic [DATA_W-1:0]     in_csr_mask,
  input  logic [DATA_W-1:0]     in_csr_wdata,
  input  logic [EXC_W-1:0]      in_exc,
  input  logic                  in_ertn,
  input  logic [DATA_W-1:0]     in_fault_vaddr,
  input  logic                  stall_in,
  input  logic                  cancel,
  output logic                  rf_we,
  output logic [RF_AW-1:0]      rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  csr_we,
  output logic [CSR_AW-1:0]     csr_num,
  output logic [DATA_W-1:0]     csr_mask,
  output logic [DATA_W-1:0]     csr_wdata,
  output logic [EXC_W-1:0]      wb_exc,
  output logic                  ertn_flush,
  output logic [DATA_W-1:0]     wb_pc,
  output logic [DATA_W-1:0]     wb_fault_vaddr,
  output logic [2**RF_AW-1:0]   pend_mask,
  output logic [CNT_W-1:0]      retire_cnt,
  output logic [DATA_W-1:0]     debug_wb_pc,
  output logic [3:0]            debug_wb_rf_we,
  output logic [RF_AW-1:0]      debug_wb_rf_wnum,
  output logic [DATA_W-1:0]     debug_wb_rf_wdata
);

  localparam int unsigned ENT_W = entry_w(DATA_W, RF_AW, CSR_AW, EXC_W);
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned TAG_W = RF_AW + 1;

  logic [ENT_W-1:0]              in_ent, head_ent;
  logic                          head_valid;
  logic [CW-1:0]                 count;
  logic [DEPTH-1:0]              vld;
  logic [DEPTH-1:0][TAG_W-1:0]   tags;
  logic [TAG_W-1:0]              in_tag;
  logic                          push, retire, exc_retire, head_fault;
  logic [CNT_W-1:0]              retire_cnt_q;

  logic [DATA_W-1:0] h_pc, h_rf_wdata, h_csr_mask, h_csr_wdata, h_fault_vaddr;
  logic              h_rf_we, h_csr_we, h_ertn;
  logic [RF_AW-1:0]  h_rf_waddr;
  logic [CSR_AW-1:0] h_csr_num;
  logic [EXC_W-1:0]  h_exc;

  assign in_ent = {in_pc, in_rf_we, in_rf_waddr, in_rf_wdata, in_csr_we, in_csr_num,
                   in_csr_mask, in_csr_wdata, in_exc, in_ertn, in_fault_vaddr};
  // Tag carries only what the hazard mask needs: "will write a GPR" and which one.
  assign in_tag = {in_rf_we & ~(|in_exc), in_rf_waddr};

  assign {h_pc, h_rf_we, h_rf_waddr, h_rf_wdata, h_csr_we, h_csr_num,
          h_csr_mask, h_csr_wdata, h_exc, h_ertn, h_fault_vaddr} = head_ent;

  assign head_fault = (|h_exc) | h_ertn;
  assign retire     = head_valid & ~stall_in & ~cancel & resetn;
  assign exc_retire = retire & head_fault;
  assign in_allowin = ~cancel & ~exc_retire & ((count < CW'(DEPTH)) | retire);
  assign push       = in_valid & in_allowin;

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W),
    .TAG_W (TAG_W)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (push),
    .pop        (retire),
    .flush      (cancel | exc_retire),
    .wdata      (in_ent),
    .wtag       (in_tag),
    .head       (head_ent),
    .head_valid (head_valid),
    .count      (count),
    .vld        (vld),
    .tags       (tags)
  );

  always_comb begin
    rf_we          = retire & ~head_fault & h_rf_we & (h_rf_waddr != '0);
    csr_we         = retire & ~head_fault & h_csr_we;
    ertn_flush     = retire & h_ertn;
    rf_waddr       = retire ? h_rf_waddr    : '0;
    rf_wdata       = retire ? h_rf_wdata    : '0;
    csr_num        = retire ? h_csr_num     : '0;
    csr_mask       = retire ? h_csr_mask    : '0;
    csr_wdata      = retire ? h_csr_wdata   : '0;
    wb_exc         = retire ? h_exc         : '0;
    wb_pc          = retire ? h_pc          : '0;
    wb_fault_vaddr = retire ? h_fault_vaddr : '0;
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && tags[i][RF_AW]) begin
        pend_mask[tags[i][RF_AW-1:0]] = 1'b1;
      end
    end
    pend_mask[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      retire_cnt_q <= '0;
    end else if (retire) begin
      retire_cnt_q <= retire_cnt_q + 1'b1;
    end
  end

  assign retire_cnt        = retire_cnt_q;
  assign debug_wb_pc       = wb_pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_commit_buf.sv
// Directed bench for wb_commit_buf: DEPTH=2 and a 3-bit retire counter so wrap is reachable.
module tb_wb_commit_buf;
  import wb_pkg::*;

  logic        clk, resetn;
  logic        in_valid, in_allowin;
  logic [31:0] in_pc, in_rf_wdata, in_csr_mask, in_csr_wdata, in_fault_vaddr;
  logic        in_rf_we, in_csr_we, in_ertn;
  logic [4:0]  in_rf_waddr;
  logic [13:0] in_csr_num;
  logic [5:0]  in_exc;
  logic        stall_in, cancel;
  logic        rf_we, csr_we, ertn_flush;
  logic [4:0]  rf_waddr, debug_wb_rf_wnum;
  logic [31:0] rf_wdata, csr_mask, csr_wdata, wb_pc, wb_fault_vaddr, pend_mask;
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
  logic [13:0] csr_num;
  logic [5:0]  wb_exc;
  logic [2:0]  retire_cnt;
  logic [3:0]  debug_wb_rf_we;

  int          total = 0;
  int          bad = 0;
  logic [2:0]  exp_cnt = '0;

  wb_commit_buf #(.DEPTH(2), .CNT_W(3)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_allowin(in_allowin),
    .in_pc(in_pc), .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr), .in_rf_wdata(in_rf_wdata),
    .in_csr_we(in_csr_we), .in_csr_num(in_csr_num), .in_csr_mask(in_csr_mask),
    .in_csr_wdata(in_csr_wdata), .in_exc(in_exc), .in_ertn(in_ertn),
    .in_fault_vaddr(in_fault_vaddr), .stall_in(stall_in), .cancel(cancel),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .csr_we(csr_we),
    .csr_num(csr_num), .csr_mask(csr_mask), .csr_wdata(csr_wdata), .wb_exc(wb_exc),
    .ertn_flush(ertn_flush), .wb_pc(wb_pc), .wb_fault_vaddr(wb_fault_vaddr),
    .pend_mask(pend_mask), .retire_cnt(retire_cnt), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_we(debug_wb_rf_we), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  function automatic wb_entry_t mk(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                                   input logic [31:0] wd);
    wb_entry_t e;
    e          = '0;
    e.pc       = pc;
    e.rf_we    = we;
    e.rf_waddr = wa;
    e.rf_wdata = wd;
    return e;
  endfunction

  task automatic drive(input logic v, input wb_entry_t e);
    in_valid       = v;
    in_pc          = e.pc;
    in_rf_we       = e.rf_we;
    in_rf_waddr    = e.rf_waddr;
    in_rf_wdata    = e.rf_wdata;
    in_csr_we      = e.csr_we;
    in_csr_num     = e.csr_num;
    in_csr_mask    = e.csr_mask;
    in_csr_wdata   = e.csr_wdata;
    in_exc         = e.exc;
    in_ertn        = e.ertn;
    in_fault_vaddr = e.fault_vaddr;
  endtask

  task automatic idle;
    drive(1'b0, mk(32'h0, 1'b0, 5'd0, 32'h0));
  endtask

  task automatic test_reset;
    smp;
    total++; if (in_allowin !== 1'b1) begin bad++;
      $display("FAIL rst_allowin got=%0h want=1", in_allowin); end
    total++; if ({rf_we, csr_we, ertn_flush, wb_exc} !== 9'h0) begin bad++;
      $display("FAIL rst_strobes got=%0h want=0", {rf_we, csr_we, ertn_flush, wb_exc}); end
    total++; if (pend_mask !== 32'h0) begin bad++;
      $display("FAIL rst_pend got=%0h want=0", pend_mask); end
    total++; if (retire_cnt !== 3'd0) begin bad++;
      $display("FAIL rst_cnt got=%0d want=0", retire_cnt); end
    tick;
  endtask

  task automatic test_single;
    wb_entry_t e;
    e           = mk(32'h1c000000, 1'b1, 5'd5, 32'h12345678);
    e.csr_we    = 1'b1;
    e.csr_num   = 14'h00c;
    e.csr_mask  = 32'h000000ff;
    e.csr_wdata = 32'h000000ab;
    drive(1'b1, e);
    smp;
    total++; if (rf_we !== 1'b0) begin bad++;
      $display("FAIL t1_no_bypass got=%0h want=0", rf_we); end
    tick;
    idle;
    smp;
    total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h12345678}) begin bad++;
      $display("FAIL t1_rf got=%0h/%0h/%0h want=1/5/12345678", rf_we, rf_waddr, rf_wdata); end
    total++; if ({debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata, debug_wb_pc}
                 !== {4'hf, 5'd5, 32'h12345678, 32'h1c000000}) begin bad++;
      $display("FAIL t1_debug got=%0h/%0h/%0h/%0h want=f/5/12345678/1c000000",
               debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata, debug_wb_pc); end
    total++; if ({csr_we, csr_num, csr_mask, csr_wdata} !== {1'b1, 14'h00c, 32'hff, 32'hab})
      begin bad++;
      $display("FAIL t1_csr got=%0h/%0h/%0h/%0h want=1/c/ff/ab",
               csr_we, csr_num, csr_mask, csr_wdata); end
    total++; if (wb_pc !== 32'h1c000000 || pend_mask !== 32'h20) begin bad++;
      $display("FAIL t1_pc_pend got=%0h/%0h want=1c000000/20", wb_pc, pend_mask); end
    tick;
    exp_cnt++;
    smp;
    total++; if (retire_cnt !== 3'd1 || rf_we !== 1'b0 || pend_mask !== 32'h0) begin bad++;
      $display("FAIL t1_after got=%0d/%0h/%0h want=1/0/0", retire_cnt, rf_we, pend_mask); end
    tick;
  endtask

  task automatic test_stall;
    stall_in = 1'b1;
    drive(1'b1, mk(32'h100, 1'b1, 5'd1, 32'ha1));
    tick;
    drive(1'b1, mk(32'h104, 1'b1, 5'd2, 32'ha2));
    smp;
    total++; if (in_allowin !== 1'b1) begin bad++;
      $display("FAIL t2_allow_one got=%0h want=1", in_allowin); end
    tick;
    drive(1'b1, mk(32'h108, 1'b1, 5'd3, 32'ha3));
    smp;
    total++; if (in_allowin !== 1'b0 || rf_we !== 1'b0) begin bad++;
      $display("FAIL t2_full got=%0h/%0h want=0/0", in_allowin, rf_we); end
    total++; if (pend_mask !== 32'h6) begin bad++;
      $display("FAIL t2_pend_full got=%0h want=6", pend_mask); end
    tick;
    stall_in = 1'b0;
    idle;
    smp;
    total++; if ({rf_we, rf_waddr, wb_pc, pend_mask} !== {1'b1, 5'd1, 32'h100, 32'h6})
      begin bad++;
      $display("FAIL t2_ret1 got=%0h/%0h/%0h/%0h want=1/1/100/6",
               rf_we, rf_waddr, wb_pc, pend_mask); end
    tick;
    exp_cnt++;
    smp;
    total++; if ({rf_we, rf_waddr, wb_pc, pend_mask} !== {1'b1, 5'd2, 32'h104, 32'h4})
      begin bad++;
      $display("FAIL t2_ret2 got=%0h/%0h/%0h/%0h want=1/2/104/4",
               rf_we, rf_waddr, wb_pc, pend_mask); end
    tick;
    exp_cnt++;
    smp;
    total++; if (rf_we !== 1'b0 || pend_mask !== 32'h0 || retire_cnt !== exp_cnt) begin bad++;
      $display("FAIL t2_drained got=%0h/%0h/%0d want=0/0/%0d",
               rf_we, pend_mask, retire_cnt, exp_cnt); end
    tick;
  endtask

  task automatic test_exc_flush;
    wb_entry_t e;
    e             = mk(32'h200, 1'b1, 5'd4, 32'hb4);
    e.exc         = 6'h01;
    e.fault_vaddr = 32'hdead0000;
    stall_in = 1'b1;
    drive(1'b1, e);
    tick;
    drive(1'b1, mk(32'h204, 1'b1, 5'd7, 32'hb7));
    tick;
    idle;
    smp;
    total++; if (pend_mask !== 32'h80) begin bad++;
      $display("FAIL t3_pend_skip_exc got=%0h want=80", pend_mask); end
    tick;
    stall_in = 1'b0;
    smp;
    total++; if ({wb_exc, rf_we, wb_pc} !== {6'h01, 1'b0, 32'h200}) begin bad++;
      $display("FAIL t3_exc got=%0h/%0h/%0h want=1/0/200", wb_exc, rf_we, wb_pc); end
    total++; if (wb_fault_vaddr !== 32'hdead0000 || in_allowin !== 1'b0) begin bad++;
      $display("FAIL t3_fault got=%0h/%0h want=dead0000/0", wb_fault_vaddr, in_allowin); end
    tick;
    exp_cnt++;
    smp;
    total++; if ({wb_exc, rf_we, pend_mask, in_allowin} !== {6'h0, 1'b0, 32'h0, 1'b1})
      begin bad++;
      $display("FAIL t3_flushed got=%0h/%0h/%0h/%0h want=0/0/0/1",
               wb_exc, rf_we, pend_mask, in_allowin); end
    total++; if (retire_cnt !== exp_cnt) begin bad++;
      $display("FAIL t3_cnt got=%0d want=%0d", retire_cnt, exp_cnt); end
    tick;
    smp;
    total++; if (rf_we !== 1'b0) begin bad++;
      $display("FAIL t3_no_late_write got=%0h want=0", rf_we); end
    tick;
  endtask

  task automatic test_ertn;
    wb_entry_t e;
    e      = mk(32'h300, 1'b0, 5'd0, 32'h0);
    e.ertn = 1'b1;
    drive(1'b1, e);
    tick;
    drive(1'b1, mk(32'h304, 1'b1, 5'd9, 32'hc9));
    smp;
    total++; if ({ertn_flush, in_allowin, rf_we, wb_pc} !== {1'b1, 1'b0, 1'b0, 32'h300})
      begin bad++;
      $display("FAIL t4_ertn got=%0h/%0h/%0h/%0h want=1/0/0/300",
               ertn_flush, in_allowin, rf_we, wb_pc); end
    tick;
    exp_cnt++;
    idle;
    smp;
    total++; if ({ertn_flush, rf_we, pend_mask} !== {1'b0, 1'b0, 32'h0}) begin bad++;
      $display("FAIL t4_after got=%0h/%0h/%0h want=0/0/0", ertn_flush, rf_we, pend_mask); end
    total++; if (retire_cnt !== exp_cnt) begin bad++;
      $display("FAIL t4_cnt got=%0d want=%0d", retire_cnt, exp_cnt); end
    tick;
  endtask

  task automatic test_cancel;
    wb_entry_t e;
    e        = mk(32'h400, 1'b1, 5'd10, 32'hd0);
    e.csr_we = 1'b1;
    stall_in = 1'b1;
    drive(1'b1, e);
    tick;
    drive(1'b1, mk(32'h404, 1'b1, 5'd11, 32'hd1));
    tick;
    stall_in = 1'b0;
    cancel   = 1'b1;
    drive(1'b1, mk(32'h408, 1'b1, 5'd12, 32'hd2));
    smp;
    total++; if ({rf_we, csr_we, ertn_flush, wb_exc, in_allowin} !== 10'h0) begin bad++;
      $display("FAIL t5_strobes got=%0h/%0h/%0h/%0h/%0h want=0",
               rf_we, csr_we, ertn_flush, wb_exc, in_allowin); end
    total++; if (pend_mask !== 32'h0c00) begin bad++;
      $display("FAIL t5_pend got=%0h want=c00", pend_mask); end
    tick;
    cancel = 1'b0;
    idle;
    smp;
    total++; if ({in_allowin, rf_we, pend_mask} !== {1'b1, 1'b0, 32'h0}) begin bad++;
      $display("FAIL t5_empty got=%0h/%0h/%0h want=1/0/0", in_allowin, rf_we, pend_mask); end
    total++; if (retire_cnt !== exp_cnt) begin bad++;
      $display("FAIL t5_cnt got=%0d want=%0d", retire_cnt, exp_cnt); end
    tick;
  endtask

  task automatic test_back_to_back;
    stall_in = 1'b1;
    drive(1'b1, mk(32'h500, 1'b1, 5'd13, 32'he0));
    tick;
    drive(1'b1, mk(32'h504, 1'b1, 5'd14, 32'he1));
    tick;
    stall_in = 1'b0;
    drive(1'b1, mk(32'h508, 1'b1, 5'd15, 32'he2));
    smp;
    total++; if ({in_allowin, rf_we, rf_waddr} !== {1'b1, 1'b1, 5'd13}) begin bad++;
      $display("FAIL t6_full_accept got=%0h/%0h/%0d want=1/1/13",
               in_allowin, rf_we, rf_waddr); end
    tick;
    exp_cnt++;
    drive(1'b1, mk(32'h50c, 1'b1, 5'd16, 32'he3));
    smp;
    total++; if ({in_allowin, rf_waddr, pend_mask} !== {1'b1, 5'd14, 32'h0000c000}) begin bad++;
      $display("FAIL t6_second got=%0h/%0d/%0h want=1/14/c000",
               in_allowin, rf_waddr, pend_mask); end
    tick;
    exp_cnt++;
    idle;
    smp;
    total++; if ({rf_waddr, rf_wdata, pend_mask} !== {5'd15, 32'he2, 32'h00018000}) begin bad++;
      $display("FAIL t6_third got=%0d/%0h/%0h want=15/e2/18000", rf_waddr, rf_wdata, pend_mask);
    end
    tick;
    exp_cnt++;
    smp;
    total++; if ({rf_we, rf_waddr, wb_pc} !== {1'b1, 5'd16, 32'h50c}) begin bad++;
      $display("FAIL t6_fourth got=%0h/%0d/%0h want=1/16/50c", rf_we, rf_waddr, wb_pc); end
    tick;
    exp_cnt++;
    smp;
    total++; if (rf_we !== 1'b0 || retire_cnt !== exp_cnt) begin bad++;
      $display("FAIL t6_cnt got=%0h/%0d want=0/%0d", rf_we, retire_cnt, exp_cnt); end
    tick;
  endtask

  task automatic test_reset_mid;
    drive(1'b1, mk(32'h600, 1'b1, 5'd3, 32'hf3));
    tick;
    idle;
    resetn = 1'b0;
    smp;
    total++; if (rf_we !== 1'b0 || wb_pc !== 32'h0) begin bad++;
      $display("FAIL t7_rst_strobe got=%0h/%0h want=0/0", rf_we, wb_pc); end
    tick;
    resetn  = 1'b1;
    exp_cnt = '0;
    smp;
    total++; if ({pend_mask, retire_cnt, in_allowin, rf_we} !== {32'h0, 3'd0, 1'b1, 1'b0})
      begin bad++;
      $display("FAIL t7_after got=%0h/%0d/%0h/%0h want=0/0/1/0",
               pend_mask, retire_cnt, in_allowin, rf_we); end
    tick;
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 8 && exp_cnt != 3'd7; i++) begin
      drive(1'b1, mk(32'h700 + 32'(4 * i), 1'b1, 5'd1, 32'(i)));
      tick;
      idle;
      tick;
      exp_cnt++;
    end
    smp;
    total++; if (retire_cnt !== 3'd7) begin bad++;
      $display("FAIL t8_max got=%0d want=7", retire_cnt); end
    tick;
    drive(1'b1, mk(32'h7f0, 1'b1, 5'd2, 32'h55));
    tick;
    idle;
    tick;
    exp_cnt++;
    smp;
    total++; if (retire_cnt !== 3'd0) begin bad++;
      $display("FAIL t8_wrap got=%0d want=0", retire_cnt); end
    tick;
  endtask

  initial begin
    resetn   = 1'b0;
    stall_in = 1'b0;
    cancel   = 1'b0;
    idle;
    tick;
    tick;
    resetn = 1'b1;
    test_reset;
    test_single;
    test_stall;
    test_exc_flush;
    test_ertn;
    test_cancel;
    test_back_to_back;
    test_reset_mid;
    test_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
